// File: rtl/seg_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_counter_pkg
// Description : Shared defaults, width helper and direction type for the
//               segmented up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_counter_pkg;

    localparam int c_DEF_SEG_W   = 16;
    localparam int c_DEF_NUM_SEG = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic int total_w(input int seg_w, input int num_seg);
        return seg_w * num_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_counter_slice.sv
`default_nettype none
// ============================================================================
// Module      : seg_counter_slice
// Description : One counter segment with clear/load/step and terminal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_counter_slice
    import seg_counter_pkg::*;
#(
    parameter int SEG_W = c_DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [SEG_W-1:0] load_val,
    input  logic             step,
    input  dir_e             dir,
    output logic [SEG_W-1:0] seg,
    output logic             term
);

    localparam logic [SEG_W-1:0] c_ONE = {{(SEG_W-1){1'b0}}, 1'b1};

    logic [SEG_W-1:0] r_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '0;
        end else if (clr) begin
            r_seg <= '0;
        end else if (load) begin
            r_seg <= load_val;
        end else if (step) begin
            r_seg <= (dir == DIR_UP) ? (r_seg + c_ONE) : (r_seg - c_ONE);
        end
    end

    // Terminal means "next step carries/borrows into the segment above".
    assign term = (dir == DIR_UP) ? (&r_seg) : ~(|r_seg);
    assign seg  = r_seg;

endmodule
`default_nettype wire

// File: rtl/seg_counter.sv
`default_nettype none
// ============================================================================
// Module      : seg_counter
// Description : Parametrised segmented up/down counter with compare, wrap,
//               sticky overflow and coherent snapshot readout.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_counter
    import seg_counter_pkg::*;
#(
    parameter int SEG_W   = c_DEF_SEG_W,
    parameter int NUM_SEG = c_DEF_NUM_SEG
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       load,
    input  logic [SEG_W*NUM_SEG-1:0]   load_val,
    input  logic                       cnt_en,
    input  logic                       up_dn,
    input  logic [SEG_W*NUM_SEG-1:0]   cmp_val,
    input  logic                       ovf_clr,
    input  logic                       snap_req,
    output logic [SEG_W*NUM_SEG-1:0]   cnt,
    output logic                       cmp_hit,
    output logic                       wrap,
    output logic                       ovf_sticky,
    output logic                       snap_valid,
    output logic [SEG_W*NUM_SEG-1:0]   snap_data
);

    localparam int c_TOTAL_W = total_w(SEG_W, NUM_SEG);

    dir_e                            w_dir;
    logic [NUM_SEG-1:0]              w_step;
    logic [NUM_SEG-1:0]              w_term;
    logic [NUM_SEG-1:0][SEG_W-1:0]   w_segs;
    logic                            w_wrap_evt;

    logic                            r_wrap;
    logic                            r_ovf;
    logic                            r_snap_valid;
    logic [c_TOTAL_W-1:0]            r_snap_data;

    assign w_dir     = dir_e'(up_dn);
    assign w_step[0] = cnt_en;

    // Each upper segment steps only when counting and all lower ones are terminal.
    for (genvar k = 1; k < NUM_SEG; k++) begin : g_carry
        assign w_step[k] = w_step[k-1] & w_term[k-1];
    end

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_slice
        seg_counter_slice #(
            .SEG_W(SEG_W)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .load     (load),
            .load_val (load_val[k*SEG_W +: SEG_W]),
            .step     (w_step[k]),
            .dir      (w_dir),
            .seg      (w_segs[k]),
            .term     (w_term[k])
        );
    end

    assign w_wrap_evt = w_step[NUM_SEG-1] & w_term[NUM_SEG-1] & ~clr & ~load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap       <= 1'b0;
            r_ovf        <= 1'b0;
            r_snap_valid <= 1'b0;
            r_snap_data  <= '0;
        end else begin
            r_wrap       <= w_wrap_evt;
            r_snap_valid <= snap_req;
            if (w_wrap_evt) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (snap_req) begin
                r_snap_data <= w_segs;
            end
        end
    end

    assign cnt        = w_segs;
    assign cmp_hit    = (w_segs == cmp_val);
    assign wrap       = r_wrap;
    assign ovf_sticky = r_ovf;
    assign snap_valid = r_snap_valid;
    assign snap_data  = r_snap_data;

endmodule
`default_nettype wire

// File: tb/tb_seg_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_counter
// Description : Scoreboard bench for seg_counter (SEG_W=4, NUM_SEG=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_counter;

    localparam int SEG_W   = 4;
    localparam int NUM_SEG = 2;
    localparam int TW      = SEG_W * NUM_SEG;
    localparam int MOD     = 1 << TW;

    logic          clk = 1'b0;
    logic          rst_n, clr, load, cnt_en, up_dn, ovf_clr, snap_req;
    logic [TW-1:0] load_val, cmp_val;
    logic [TW-1:0] cnt, snap_data;
    logic          cmp_hit, wrap, ovf_sticky, snap_valid;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (integer arithmetic on the whole count)
    int m_cnt, m_snapd;
    bit m_wrap, m_ovf, m_snapv;
    int snap_q[$];

    seg_counter #(.SEG_W(SEG_W), .NUM_SEG(NUM_SEG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .cnt_en     (cnt_en),
        .up_dn      (up_dn),
        .cmp_val    (cmp_val),
        .ovf_clr    (ovf_clr),
        .snap_req   (snap_req),
        .cnt        (cnt),
        .cmp_hit    (cmp_hit),
        .wrap       (wrap),
        .ovf_sticky (ovf_sticky),
        .snap_valid (snap_valid),
        .snap_data  (snap_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_wrap = 0; m_ovf = 0; m_snapv = 0; m_snapd = 0;
            snap_q.delete();
        end else begin
            bit ev;
            ev = 0;
            m_snapv = snap_req;
            if (snap_req) begin
                snap_q.push_back(m_cnt);
                m_snapd = m_cnt;
            end
            if (clr) m_cnt = 0;
            else if (load) m_cnt = int'(load_val);
            else if (cnt_en) begin
                if (up_dn) begin
                    ev = (m_cnt == MOD - 1);
                    m_cnt = (m_cnt + 1) % MOD;
                end else begin
                    ev = (m_cnt == 0);
                    m_cnt = (m_cnt + MOD - 1) % MOD;
                end
            end
            m_wrap = ev;
            if (ev) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    // Monitor: per-cycle state compare plus snapshot scoreboard pops
    always @(negedge clk) begin
        chk("cnt", int'(cnt), m_cnt);
        chk("cmp_hit", int'(cmp_hit), int'(m_cnt == int'(cmp_val)));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("ovf_sticky", int'(ovf_sticky), int'(m_ovf));
        chk("snap_valid", int'(snap_valid), int'(m_snapv));
        chk("snap_data_hold", int'(snap_data), m_snapd);
        if (snap_valid) begin
            if (snap_q.size() == 0) chk("snap_unexpected", 1, 0);
            else chk("snap_pop", int'(snap_data), snap_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 0; clr = 0; load = 0; cnt_en = 0; up_dn = 1; ovf_clr = 0;
        snap_req = 0; load_val = '0; cmp_val = 8'h20;
        cyc(2);
        chk("reset_cnt", int'(cnt), 0);
        rst_n = 1;

        // Full up sweep with one wrap
        cnt_en = 1; up_dn = 1;
        cyc(256);
        cnt_en = 0;
        cyc(1);
        chk("sweep_ovf", int'(ovf_sticky), 1);

        // Enable gating of the carry chain
        ovf_clr = 1; cyc(1); ovf_clr = 0;
        load = 1; load_val = 8'h0F; cyc(1); load = 0;
        for (int i = 0; i < 8; i++) begin
            cnt_en = (i % 2 == 0);
            cyc(1);
        end
        cnt_en = 0;
        cyc(1);
        chk("gated_cnt", int'(cnt), 8'h13);

        // Down count across the borrow and through zero
        load = 1; load_val = 8'h10; cyc(1); load = 0;
        up_dn = 0; cnt_en = 1;
        cyc(1);
        chk("borrow", int'(cnt), 8'h0F);
        cyc(16);
        cnt_en = 0;
        chk("down_wrap_cnt", int'(cnt), 8'hFF);
        chk("down_ovf", int'(ovf_sticky), 1);
        ovf_clr = 1; cyc(1); ovf_clr = 0;
        chk("ovf_cleared", int'(ovf_sticky), 0);
        load = 1; load_val = 8'h00; cyc(1); load = 0;
        cnt_en = 1; ovf_clr = 1; cyc(1); cnt_en = 0; ovf_clr = 0;
        chk("ovf_set_wins", int'(ovf_sticky), 1);

        // Priority clr > load > count
        clr = 1; load = 1; cnt_en = 1; up_dn = 1; load_val = 8'h55; cyc(1);
        chk("clr_prio", int'(cnt), 0);
        clr = 0; cyc(1);
        chk("load_prio", int'(cnt), 8'h55);
        load = 0; cnt_en = 0; cyc(1);

        // Snapshots, single and back-to-back
        load = 1; load_val = 8'h38; cyc(1); load = 0;
        cnt_en = 1; cyc(2);
        snap_req = 1; cyc(1); snap_req = 0;
        cyc(4);
        chk("snap_held", int'(snap_data), 8'h3A);
        snap_req = 1; cyc(3); snap_req = 0;
        cyc(2);

        // Compare match, then async reset mid-count
        load = 1; load_val = 8'h1C; cyc(1); load = 0;
        cnt_en = 1; cyc(8);
        #2 rst_n = 0;
        #1;
        chk("async_rst_cnt", int'(cnt), 0);
        chk("async_rst_cmp", int'(cmp_hit), 0);
        cyc(1);
        rst_n = 1;
        cyc(3);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            clr      = ($urandom_range(31) == 0);
            load     = ($urandom_range(15) == 0);
            cnt_en   = ($urandom_range(3) != 0);
            up_dn    = 1'($urandom_range(1));
            ovf_clr  = ($urandom_range(15) == 0);
            snap_req = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0: load_val = 8'hFF;
                1: load_val = 8'h00;
                default: load_val = 8'($urandom);
            endcase
            if ($urandom_range(31) == 0) cmp_val = 8'($urandom);
            cyc(1);
        end
        clr = 0; load = 0; cnt_en = 0; ovf_clr = 0; snap_req = 0;
        cyc(3);
        chk("snap_q_empty", snap_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
